// File: rtl/gain_core_mc_pkg.sv
// Shared constants, state encoding and helpers for the multi-channel complex gain core.
package gain_core_mc_pkg;

  localparam int DEF_NUM_CHAN  = 2;
  localparam int DEF_ITEM_W    = 16;
  localparam int DEF_GAIN_W    = 16;
  localparam int DEF_GAIN_FRAC = 8;

  localparam logic [3:0] ADDR_CTRL       = 4'hF;
  localparam int         CTRL_BYPASS_BIT = 0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_t;

  // Gain code that represents 1.0 for a given number of fractional bits.
  function automatic logic [31:0] unity_gain(input int gain_frac);
    return 32'd1 << gain_frac;
  endfunction

endpackage

// File: rtl/gain_core_mc_mul.sv
// One component of the gain datapath: signed x unsigned multiply, round half up,
// arithmetic shift and clip to the sample range, with a clip flag.
module gain_mul_rnd_sat
  import gain_core_mc_pkg::*;
#(
  parameter int ITEM_W    = DEF_ITEM_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic signed [ITEM_W-1:0] x,
  input  logic        [GAIN_W-1:0] gain,
  input  logic                     bypass,
  output logic        [ITEM_W-1:0] y,
  output logic                     sat
);

  // Two guard bits: one for the unsigned gain's sign, one for the rounding add.
  localparam int P_W = ITEM_W + GAIN_W + 2;

  localparam logic signed [P_W-1:0] HALF  = {{(P_W-1){1'b0}}, 1'b1} << (GAIN_FRAC-1);
  localparam logic signed [P_W-1:0] MAX_V = {{(P_W-ITEM_W+1){1'b0}}, {(ITEM_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] MIN_V = {{(P_W-ITEM_W+1){1'b1}}, {(ITEM_W-1){1'b0}}};

  logic signed [P_W-1:0] x_ext;
  logic signed [P_W-1:0] g_ext;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] rounded;
  logic signed [P_W-1:0] shifted;

  assign x_ext   = {{(P_W-ITEM_W){x[ITEM_W-1]}}, x};
  assign g_ext   = {{(P_W-GAIN_W){1'b0}}, gain};
  assign prod    = x_ext * g_ext;
  assign rounded = prod + HALF;
  assign shifted = rounded >>> GAIN_FRAC;

  always_comb begin
    y   = shifted[ITEM_W-1:0];
    sat = 1'b0;
    if (bypass) begin
      y = x;
    end else if (shifted > MAX_V) begin
      y   = {1'b0, {(ITEM_W-1){1'b1}}};
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      y   = {1'b1, {(ITEM_W-1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/gain_core_mc.sv
// Multi-channel complex gain stage on AXI-Stream: two-register elastic pipeline,
// packet-aligned gain updates from shadow registers, and a saturation counter.
module gain_core_mc
  import gain_core_mc_pkg::*;
#(
  parameter int NUM_CHAN  = DEF_NUM_CHAN,
  parameter int ITEM_W    = DEF_ITEM_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic                           ce_clk,
  input  logic                           ce_rst_n,
  input  logic [NUM_CHAN*2*ITEM_W-1:0]   s_axis_tdata,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [NUM_CHAN*2*ITEM_W-1:0]   m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  input  logic                           cfg_wr_en,
  input  logic [3:0]                     cfg_addr,
  input  logic [31:0]                    cfg_data,
  input  logic                           sat_clr,
  output logic [31:0]                    sat_count
);

  localparam int NUM_COMP = 2 * NUM_CHAN;
  localparam int DATA_W   = NUM_COMP * ITEM_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));

  pkt_state_t        state;
  logic [GAIN_W-1:0] pend_gain [NUM_CHAN];
  logic [GAIN_W-1:0] act_gain  [NUM_CHAN];
  logic              pend_bypass;
  logic              act_bypass;

  logic              s0_valid;
  logic              s0_last;
  logic              s0_bypass;
  logic [DATA_W-1:0] s0_data;
  logic [GAIN_W-1:0] s0_gain [NUM_CHAN];

  logic              out_sat;
  logic [DATA_W-1:0] scaled;
  logic [NUM_COMP-1:0] comp_sat;

  logic out_ready;
  logic s0_ready;
  logic in_accept;
  logic load_active;
  logic ctrl_hit;
  logic unused_cfg;

  assign out_ready     = !m_axis_tvalid || m_axis_tready;
  assign s0_ready      = !s0_valid || out_ready;
  assign s_axis_tready = ce_rst_n && s0_ready;
  assign in_accept     = s_axis_tvalid && s_axis_tready;
  // Shadow values only take effect between packets, never in the middle of one.
  assign load_active   = (state == ST_IDLE) || (in_accept && s_axis_tlast);
  assign ctrl_hit      = cfg_wr_en && (cfg_addr == ADDR_CTRL);
  assign unused_cfg    = ^cfg_data;

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state <= ST_IDLE;
    end else if (in_accept) begin
      state <= s_axis_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        pend_gain[i] <= UNITY;
        act_gain[i]  <= UNITY;
      end
      pend_bypass <= 1'b0;
      act_bypass  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (cfg_wr_en && (cfg_addr == 4'(i)))
          pend_gain[i] <= cfg_data[GAIN_W-1:0];
        if (load_active)
          act_gain[i] <= pend_gain[i];
      end
      if (ctrl_hit)
        pend_bypass <= cfg_data[CTRL_BYPASS_BIT];
      if (load_active)
        act_bypass <= pend_bypass;
    end
  end

  // Stage 0 snapshots the active settings with the beat, so a config write in the
  // acceptance cycle cannot affect that beat.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      s0_valid  <= 1'b0;
      s0_last   <= 1'b0;
      s0_bypass <= 1'b0;
      s0_data   <= '0;
      for (int i = 0; i < NUM_CHAN; i++)
        s0_gain[i] <= UNITY;
    end else if (s0_ready) begin
      s0_valid <= in_accept;
      if (in_accept) begin
        s0_data   <= s_axis_tdata;
        s0_last   <= s_axis_tlast;
        s0_bypass <= act_bypass;
        for (int i = 0; i < NUM_CHAN; i++)
          s0_gain[i] <= act_gain[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_COMP; gi++) begin : g_comp
    gain_mul_rnd_sat #(
      .ITEM_W    (ITEM_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
    ) u_mul (
      .x      (s0_data[gi*ITEM_W +: ITEM_W]),
      .gain   (s0_gain[gi/2]),
      .bypass (s0_bypass),
      .y      (scaled[gi*ITEM_W +: ITEM_W]),
      .sat    (comp_sat[gi])
    );
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      out_sat       <= 1'b0;
    end else if (out_ready) begin
      m_axis_tvalid <= s0_valid;
      if (s0_valid) begin
        m_axis_tdata <= scaled;
        m_axis_tlast <= s0_last;
        out_sat      <= |comp_sat;
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 32'd1;
    end
  end

endmodule
